// File: rtl/uart_aes_cmd_ctrl.sv
// uart_aes_cmd_ctrl: UART command parser feeding an AES core; `UART_AES_CMD_TIMEOUT_EN adds a payload idle timeout
module uart_aes_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter logic [7:0] CMD_KEY = 8'h4B,
  parameter logic [7:0] CMD_ENC = 8'h50,
  parameter logic [7:0] RSP_ACK = 8'h06,
  parameter logic [7:0] RSP_NAK = 8'h15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_data_en,
  output logic [7:0]   tx_data,
  output logic         tx_data_en,
  input  logic         tx_busy,
  output logic [127:0] aes_key,
  output logic [127:0] aes_din,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_dout,
  output logic         key_valid
);
  typedef enum logic [2:0] {IDLE, RX_KEY, RX_PT, AES_GO, AES_WAIT, TX_LOAD, TX_ACK, TX_DONE} state_t;
  state_t state, state_nx;
  logic [4:0] rx_cnt, tx_rem;
  logic [127:0] stage, shreg;
  logic [25:0] idle_cnt;
  logic last_byte, in_rx, timeout;
`ifdef UART_AES_CMD_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  assign in_rx = state == RX_KEY || state == RX_PT;
  assign last_byte = rx_data_en && rx_cnt == 5'd15;
  assign timeout = TIMEOUT_EN && in_rx && !rx_data_en && idle_cnt == 26'(TIMEOUT_CYCLES);
  assign aes_start = state == AES_GO;
  always_ff @(posedge clk)
    idle_cnt <= (rst || rx_data_en || !in_rx) ? '0 : idle_cnt + 26'd1;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (rx_data_en) state_nx = rx_data == CMD_KEY ? RX_KEY : rx_data == CMD_ENC ? RX_PT : TX_LOAD;
      RX_KEY:   if (timeout || last_byte) state_nx = TX_LOAD;
      RX_PT:    if (timeout) state_nx = TX_LOAD;
                else if (last_byte) state_nx = key_valid ? AES_GO : TX_LOAD;
      AES_GO:   state_nx = AES_WAIT;
      AES_WAIT: if (aes_done) state_nx = TX_LOAD;
      TX_LOAD:  state_nx = TX_ACK;
      TX_ACK:   if (tx_busy) state_nx = TX_DONE;
      TX_DONE:  if (!tx_busy) state_nx = tx_rem != 5'd0 ? TX_LOAD : IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  // Keys shift through a staging register so a partial key never disturbs aes_key
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data <= 8'h00;
      tx_data_en <= 1'b0;
      aes_key <= '0;
      aes_din <= '0;
      key_valid <= 1'b0;
      stage <= '0;
      shreg <= '0;
      rx_cnt <= '0;
      tx_rem <= '0;
    end else begin
      case (state)
        IDLE: if (rx_data_en) begin
          rx_cnt <= '0;
          shreg <= {RSP_NAK, 120'd0};
          tx_rem <= 5'd1;
        end
        RX_KEY: if (timeout) begin
          shreg <= {RSP_NAK, 120'd0};
          tx_rem <= 5'd1;
        end else if (rx_data_en) begin
          stage <= {stage[119:0], rx_data};
          rx_cnt <= rx_cnt + 5'd1;
          if (last_byte) begin
            aes_key <= {stage[119:0], rx_data};
            key_valid <= 1'b1;
            shreg <= {RSP_ACK, 120'd0};
            tx_rem <= 5'd1;
          end
        end
        RX_PT: if (timeout) begin
          shreg <= {RSP_NAK, 120'd0};
          tx_rem <= 5'd1;
        end else if (rx_data_en) begin
          aes_din <= {aes_din[119:0], rx_data};
          rx_cnt <= rx_cnt + 5'd1;
          if (last_byte && !key_valid) begin
            shreg <= {RSP_NAK, 120'd0};
            tx_rem <= 5'd1;
          end
        end
        AES_WAIT: if (aes_done) begin
          shreg <= aes_dout;
          tx_rem <= 5'd16;
        end
        TX_LOAD: begin
          tx_data <= shreg[127:120];
          tx_data_en <= 1'b1;
        end
        TX_ACK: if (tx_busy) begin
          tx_data_en <= 1'b0;
          shreg <= {shreg[119:0], 8'h00};
          tx_rem <= tx_rem - 5'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_aes_cmd_ctrl.sv
// tb_uart_aes_cmd_ctrl: scoreboard bench for uart_aes_cmd_ctrl with UART transceiver and AES core models
module tb_uart_aes_cmd_ctrl;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0;
  logic rx_data_en = 0, tx_busy = 0, aes_done = 0;
  logic [7:0] tx_data;
  logic tx_data_en, aes_start, key_valid;
  logic [127:0] aes_key, aes_din, aes_dout = 0;
  int n_chk = 0, n_fail = 0, busy_len = 20, rises = 0;
  logic [7:0] exp_tx[$];
  logic [127:0] exp_start[$];
  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;

  always #5 clk = ~clk;

  uart_aes_cmd_ctrl #(.TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_en(rx_data_en),
    .tx_data(tx_data), .tx_data_en(tx_data_en), .tx_busy(tx_busy),
    .aes_key(aes_key), .aes_din(aes_din), .aes_start(aes_start),
    .aes_done(aes_done), .aes_dout(aes_dout), .key_valid(key_valid)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  task automatic check_reset();
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_data_en", tx_data_en, 0);
    check("rst_aes_key", aes_key, 0);
    check("rst_aes_din", aes_din, 0);
    check("rst_aes_start", aes_start, 0);
    check("rst_key_valid", key_valid, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_data_en = 1;
    @(negedge clk);
    rx_data_en = 0;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [127:0] d, input int n);
    logic [127:0] s;
    s = d;
    send_byte(c);
    for (int i = 0; i < n; i++) begin
      send_byte(s[127:120]);
      s = s << 8;
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && !tx_busy && !tx_data_en) break;
    end
    repeat (3) @(negedge clk);
    check("idle_within_budget", i < 30000, 1);
  endtask

  task automatic push_bytes(input logic [127:0] d);
    for (int i = 15; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
  endtask

  // UART transceiver model: busy follows a new request after two cycles
  initial forever begin
    @(negedge clk);
    if (tx_data_en && !tx_busy) begin
      repeat (2) @(negedge clk);
      tx_busy = 1;
      repeat (busy_len) @(negedge clk);
      tx_busy = 0;
    end
  end

  // AES core model: knows the FIPS-197 example vector
  initial forever begin : aes_model
    logic [127:0] k, p;
    @(negedge clk);
    if (aes_start) begin
      k = aes_key;
      p = aes_din;
      repeat (10) @(negedge clk);
      aes_dout = (k == KEY && p == PT) ? CT : ~p;
      aes_done = 1;
      @(negedge clk);
      aes_done = 0;
      aes_dout = 0;
    end
  end

  // Monitor: pops the scoreboard on each tx request rise and each aes_start
  initial begin : monitor
    logic prev_en, stab_bad;
    logic [7:0] cap;
    prev_en = 0;
    stab_bad = 0;
    cap = 0;
    forever begin
      @(negedge clk);
      if (tx_data_en && !prev_en) begin
        rises++;
        cap = tx_data;
        stab_bad = 0;
        if (exp_tx.size() == 0) unexpected("tx_byte_unexpected", tx_data);
        else check("tx_byte", tx_data, exp_tx.pop_front());
      end else if (tx_data_en && tx_data !== cap) stab_bad = 1;
      if (!tx_data_en && prev_en) check("tx_data_stable", stab_bad, 0);
      prev_en = tx_data_en;
      if (aes_start) begin
        if (exp_start.size() == 0) unexpected("aes_start_unexpected", aes_din);
        else check("aes_din_at_start", aes_din, exp_start.pop_front());
      end
    end
  end

  initial begin : main
    int r0, i;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 0;
    exp_tx.push_back(8'h15);
    send_cmd(8'h50, PT, 16);
    wait_idle();
    check("key_valid_no_key", key_valid, 0);
    exp_tx.push_back(8'h06);
    send_cmd(8'h4B, KEY, 16);
    wait_idle();
    check("aes_key_loaded", aes_key, KEY);
    check("key_valid_set", key_valid, 1);
    exp_start.push_back(PT);
    push_bytes(CT);
    send_cmd(8'h50, PT, 16);
    send_byte(8'h4B);
    send_byte(8'h41);
    repeat (40) @(negedge clk);
    send_byte(8'h50);
    send_byte(8'h41);
    wait_idle();
    check("aes_din_kept", aes_din, PT);
    check("aes_key_kept", aes_key, KEY);
    exp_tx.push_back(8'h06);
    send_cmd(8'h4B, KEY2, 16);
    wait_idle();
    check("aes_key_reloaded", aes_key, KEY2);
    busy_len = 5000;
    exp_tx.push_back(8'h15);
    send_byte(8'h41);
    wait_idle();
    busy_len = 20;
    send_cmd(8'h50, PT, 5);
    rst = 1;
    @(negedge clk);
    check_reset();
    rst = 0;
    repeat (50) @(negedge clk);
    exp_tx.push_back(8'h06);
    send_cmd(8'h4B, KEY, 16);
    wait_idle();
    exp_start.push_back(PT);
    push_bytes(CT);
    r0 = rises;
    send_cmd(8'h50, PT, 16);
    for (i = 0; i < 5000 && rises < r0 + 3; i++) @(negedge clk);
    check("three_bytes_before_reset", rises >= r0 + 3, 1);
    rst = 1;
    @(negedge clk);
    check_reset();
    exp_tx.delete();
    rst = 0;
    repeat (200) @(negedge clk);
`ifdef UART_AES_CMD_TIMEOUT_EN
    exp_tx.push_back(8'h06);
    send_cmd(8'h4B, KEY, 16);
    wait_idle();
    r0 = rises;
    exp_tx.push_back(8'h15);
    send_cmd(8'h4B, KEY2, 5);
    for (i = 0; i < 990 && rises == r0; i++) @(negedge clk);
    check("no_nak_before_timeout", rises, r0);
    wait_idle();
    check("aes_key_after_timeout", aes_key, KEY);
    check("key_valid_after_timeout", key_valid, 1);
`endif
    check("tx_queue_drained", exp_tx.size(), 0);
    check("start_queue_drained", exp_start.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
